ext_link_xcvr: RTL and testbench
================================

# ext_link_xcvr

Parametrised half-duplex serial link transceiver for board-to-board external communication over GPIO. Each side has one data line and one acknowledge line. It serialises a word from the local bus side into a framed serial stream with a sequence bit and optional parity. It waits for a remote acknowledge and retransmits on timeout. It also receives, checks and acknowledges frames from the remote board, discarding duplicates.

## Interface
Parameters:
- DATA_W, 8, payload width in bits.
- CLKS_PER_BIT, 16, clk cycles per serial bit (≥4, even).
- ACK_TIMEOUT, 1024, cycles to wait for ack after stop bit.
- MAX_RETRY, 3, retransmissions before declaring failure.
- PARITY_EN, 1, 1 = even parity bit present in frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- tx_data  in  DATA_W  word to send, sampled when tx_start is accepted.
- tx_start  in  1  send request, accepted only when tx_busy = 0.
- tx_busy  out  1  high from the cycle after acceptance until tx_done/tx_fail.
- tx_done  out  1  one-cycle pulse: frame acknowledged.
- tx_fail  out  1  one-cycle pulse: retries exhausted.
- rx_data  out  DATA_W  last accepted payload, held.
- rx_valid  out  1  one-cycle pulse: new non-duplicate payload on rx_data.
- rx_err  out  1  one-cycle pulse: parity or stop-bit error.
- ext_data_out  out  1  serial line to remote, idle high.
- ext_data_in  in  1  serial line from remote (asynchronous).
- ack_out  out  1  acknowledge to remote.
- ack_in  in  1  acknowledge from remote (asynchronous).
- state_tx  out  3  tx FSM encoding, debug.
- state_rx  out  3  rx FSM encoding, debug.

## Operation
- Frame, LSB first: start(0), seq bit, DATA_W data bits, parity (if PARITY_EN, even over seq+data), stop(1). Length F = DATA_W+3+PARITY_EN bits.
- TX FSM: IDLE(0) → START(1) → SEQ(2) → DATA(3) → PAR(4, skipped if PARITY_EN=0) → STOP(5) → WAIT_ACK(6).
- WAIT_ACK, rising edge on synchronised ack_in → tx_done, IDLE, tx_seq toggles.
- WAIT_ACK, ACK_TIMEOUT cycles elapse with retry count < MAX_RETRY → retry count +1, back to START with the same data and seq.
- WAIT_ACK, timeout with retry count = MAX_RETRY → tx_fail, IDLE, tx_seq toggles.
- ack_in edges outside WAIT_ACK are ignored. tx_start while busy is ignored.
- RX: ext_data_in and ack_in each pass through a 2-flop synchroniser.
- RX FSM: IDLE(0) → START(1) → SEQ(2) → DATA(3) → PAR(4) → STOP(5) → ACK(6).
- IDLE, falling edge on the line → START. Sample at CLKS_PER_BIT/2; if the line is high, treat as a glitch and return to IDLE. Later bits are sampled every CLKS_PER_BIT cycles at mid-bit.
- At STOP sample: stop=0 or parity mismatch → rx_err, IDLE, no ack.
- Good frame → ack_out high for CLKS_PER_BIT cycles (ACK state).
- If seq ≠ last_seq: load rx_data, pulse rx_valid, last_seq ← seq. Otherwise it is a duplicate: ack only, no rx_valid.
- The line is not monitored during ACK; return to IDLE afterwards.

## Timing
- Reset values: ext_data_out=1, ack_out=0, tx_busy=0, all pulses 0, rx_data=0, state_tx=state_rx=0, tx_seq=0, last_seq=1, retry count=0.
- tx_start high in cycle n with tx_busy=0 → tx_busy=1 and ext_data_out=0 from cycle n+1.
- Each bit is held exactly CLKS_PER_BIT cycles. Stop bit ends at n+1+F·CLKS_PER_BIT; the timeout counter starts there.
- Ack detection latency is 3 cycles after the ack_in edge (2 sync + edge). tx_done asserts that cycle; tx_busy drops the next cycle.
- rx_valid/rx_err assert 3 cycles + mid-stop-bit after the falling start edge. ack_out rises the same cycle as rx_valid.
- Reset asserted mid-frame aborts immediately to reset values. The line returns to idle high asynchronously.

## Test plan
- Loopback (out→in, ack_out→ack_in), CLKS_PER_BIT=4, DATA_W=8: send 0xA5 → rx_valid with rx_data=0xA5, tx_done, frame length 12 bits = 48 cycles.
- ack_in tied 0, ACK_TIMEOUT=32, MAX_RETRY=3: send 0x3C → 4 frames identical on the wire, then tx_fail; tx_busy low afterwards; next frame carries seq=1.
- Inject a flipped data bit into frame 0x0F on ext_data_in → rx_err pulse, ack_out stays 0, rx_data unchanged.
- Drive two identical good frames with seq=0 (0x11) → first gives rx_valid, second gives no rx_valid; ack_out pulses 4 cycles both times.
- 1-cycle low glitch on idle ext_data_in → no state change beyond START, returns to IDLE, no pulses.
- Assert reset during DATA of TX → ext_data_out=1, tx_busy=0 immediately. After release, tx_start sends a full frame with seq=0.

Source files
------------

// File: rtl/ext_link_xcvr.sv
// ext_link_xcvr -- half-duplex board-to-board serial link transceiver.
//
// Sends one DATA_W word per request as a framed serial stream and waits for
// a remote acknowledge, retransmitting on timeout. Receives, checks and
// acknowledges frames from the remote side, dropping duplicate frames by
// their sequence bit.
//
// Frame, LSB first: start(0), seq, DATA_W data bits, [even parity over
// seq+data], stop(1). Every bit lasts CLKS_PER_BIT clocks. DATA_W >= 2.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   tx_data, tx_start   word to send / send request (taken when !tx_busy)
//   tx_busy             transmit in progress
//   tx_done, tx_fail    one-cycle pulses: acknowledged / retries exhausted
//   rx_data             last accepted payload (held)
//   rx_valid, rx_err    one-cycle pulses: new payload / bad frame
//   ext_data_out/in     serial lines to/from remote (idle high)
//   ack_out/ack_in      acknowledge lines to/from remote
//   state_tx, state_rx  FSM encodings for debug
module ext_link_xcvr #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int ACK_TIMEOUT  = 1024,
    parameter int MAX_RETRY    = 3,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_start,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_fail,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err,
    output logic              ext_data_out,
    input  logic              ext_data_in,
    output logic              ack_out,
    input  logic              ack_in,
    output logic [2:0]        state_tx,
    output logic [2:0]        state_rx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        T_IDLE = 3'd0, T_START = 3'd1, T_SEQ = 3'd2, T_DATA = 3'd3,
        T_PAR  = 3'd4, T_STOP  = 3'd5, T_WAIT = 3'd6
    } tx_state_t;

    typedef enum logic [2:0] {
        R_IDLE = 3'd0, R_START = 3'd1, R_SEQ = 3'd2, R_DATA = 3'd3,
        R_PAR  = 3'd4, R_STOP  = 3'd5, R_ACK  = 3'd6
    } rx_state_t;

    // ------------------------------------------------------------------
    // Synchronisers. The third flop of each chain only serves edge
    // detection. The data chain resets high so reset release never looks
    // like a start bit.
    // ------------------------------------------------------------------
    logic d_s1, d_s2, d_s3;
    logic a_s1, a_s2, a_s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_s1 <= 1'b1;
            d_s2 <= 1'b1;
            d_s3 <= 1'b1;
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            a_s3 <= 1'b0;
        end else begin
            d_s1 <= ext_data_in;
            d_s2 <= d_s1;
            d_s3 <= d_s2;
            a_s1 <= ack_in;
            a_s2 <= a_s1;
            a_s3 <= a_s2;
        end
    end

    logic line_fall, ack_rise;
    assign line_fall = d_s3 & ~d_s2;
    assign ack_rise  = a_s2 & ~a_s3;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t         tx_st;
    logic [CW-1:0]     tx_cnt;
    logic [TW-1:0]     to_cnt;
    logic [RW-1:0]     retry;
    logic [IW-1:0]     tx_idx;
    logic [DATA_W-1:0] tx_word;
    logic [DATA_W-1:0] tx_sh;
    logic              tx_seq;
    logic              tx_par;

    assign tx_par = ^{tx_seq, tx_word};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_st        <= T_IDLE;
            tx_cnt       <= '0;
            to_cnt       <= '0;
            retry        <= '0;
            tx_idx       <= '0;
            tx_word      <= '0;
            tx_sh        <= '0;
            tx_seq       <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            tx_fail      <= 1'b0;
            ext_data_out <= 1'b1;
        end else begin
            tx_done <= 1'b0;
            tx_fail <= 1'b0;
            case (tx_st)
                T_IDLE: begin
                    ext_data_out <= 1'b1;
                    // tx_busy stays high for the done/fail cycle and drops
                    // one cycle later, so no request is taken in that cycle.
                    if (tx_start && !tx_busy) begin
                        tx_word      <= tx_data;
                        tx_busy      <= 1'b1;
                        retry        <= '0;
                        tx_cnt       <= '0;
                        ext_data_out <= 1'b0;
                        tx_st        <= T_START;
                    end else begin
                        tx_busy <= 1'b0;
                    end
                end
                T_WAIT: begin
                    if (ack_rise) begin
                        tx_done <= 1'b1;
                        tx_seq  <= ~tx_seq;
                        tx_st   <= T_IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        if (retry == RETRY_MAX) begin
                            tx_fail <= 1'b1;
                            tx_seq  <= ~tx_seq;
                            tx_st   <= T_IDLE;
                        end else begin
                            // Resend the same word with the same seq bit.
                            retry        <= retry + 1'b1;
                            tx_cnt       <= '0;
                            ext_data_out <= 1'b0;
                            tx_st        <= T_START;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    if (tx_cnt != BIT_LAST) begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end else begin
                        // Bit boundary: drive the next bit's value.
                        tx_cnt <= '0;
                        case (tx_st)
                            T_START: begin
                                ext_data_out <= tx_seq;
                                tx_st        <= T_SEQ;
                            end
                            T_SEQ: begin
                                ext_data_out <= tx_word[0];
                                tx_sh        <= tx_word >> 1;
                                tx_idx       <= '0;
                                tx_st        <= T_DATA;
                            end
                            T_DATA: begin
                                if (tx_idx == IDX_LAST) begin
                                    if (PARITY_EN != 0) begin
                                        ext_data_out <= tx_par;
                                        tx_st        <= T_PAR;
                                    end else begin
                                        ext_data_out <= 1'b1;
                                        tx_st        <= T_STOP;
                                    end
                                end else begin
                                    tx_idx       <= tx_idx + 1'b1;
                                    ext_data_out <= tx_sh[0];
                                    tx_sh        <= tx_sh >> 1;
                                end
                            end
                            T_PAR: begin
                                ext_data_out <= 1'b1;
                                tx_st        <= T_STOP;
                            end
                            T_STOP: begin
                                to_cnt <= '0;
                                tx_st  <= T_WAIT;
                            end
                            default: tx_st <= T_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver. The first sample lands half a bit after the detected
    // falling edge; every later sample is a full bit further on.
    // ------------------------------------------------------------------
    rx_state_t         rx_st;
    logic [CW-1:0]     rx_cnt;
    logic [IW-1:0]     rx_idx;
    logic [DATA_W-1:0] rx_sh;
    logic              rx_seq;
    logic              rx_par;
    logic              last_seq;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_st    <= R_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_sh    <= '0;
            rx_seq   <= 1'b0;
            rx_par   <= 1'b0;
            last_seq <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            ack_out  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (rx_st)
                R_IDLE: begin
                    if (line_fall) begin
                        rx_cnt <= '0;
                        rx_st  <= R_START;
                    end
                end
                R_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        // High at mid start bit: a glitch, not a frame.
                        rx_st  <= d_s2 ? R_IDLE : R_SEQ;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_ACK: begin
                    if (rx_cnt == BIT_LAST) begin
                        ack_out <= 1'b0;
                        rx_st   <= R_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt != BIT_LAST) begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end else begin
                        rx_cnt <= '0;
                        case (rx_st)
                            R_SEQ: begin
                                rx_seq <= d_s2;
                                rx_par <= d_s2;
                                rx_idx <= '0;
                                rx_st  <= R_DATA;
                            end
                            R_DATA: begin
                                rx_sh  <= {d_s2, rx_sh[DATA_W-1:1]};
                                rx_par <= rx_par ^ d_s2;
                                if (rx_idx == IDX_LAST)
                                    rx_st <= (PARITY_EN != 0) ? R_PAR : R_STOP;
                                else
                                    rx_idx <= rx_idx + 1'b1;
                            end
                            R_PAR: begin
                                rx_par <= rx_par ^ d_s2;
                                rx_st  <= R_STOP;
                            end
                            R_STOP: begin
                                if (!d_s2 || (PARITY_EN != 0 && rx_par)) begin
                                    rx_err <= 1'b1;
                                    rx_st  <= R_IDLE;
                                end else begin
                                    // Duplicates are still acknowledged so
                                    // the sender stops retrying.
                                    ack_out <= 1'b1;
                                    rx_st   <= R_ACK;
                                    if (rx_seq != last_seq) begin
                                        rx_data  <= rx_sh;
                                        rx_valid <= 1'b1;
                                        last_seq <= rx_seq;
                                    end
                                end
                            end
                            default: rx_st <= R_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign state_tx = tx_st;
    assign state_rx = rx_st;

endmodule

// File: tb/tb_ext_link_xcvr.sv
// Directed bench for ext_link_xcvr: loopback, retry/fail, bad parity,
// duplicate suppression, start glitch and mid-frame reset. Received
// payloads are checked against a scoreboard queue.
module tb_ext_link_xcvr;

    localparam int DW  = 8;
    localparam int CPB = 4;
    localparam int TO  = 32;
    localparam int MR  = 3;
    localparam int PE  = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_start = 1'b0;
    logic          tx_busy, tx_done, tx_fail;
    logic [DW-1:0] rx_data;
    logic          rx_valid, rx_err;
    logic          ext_data_out, ext_data_in;
    logic          ack_out, ack_in;
    logic [2:0]    state_tx, state_rx;

    // Line routing: loopback or bench-driven.
    logic loop = 1'b0;
    logic drv_data = 1'b1;
    logic drv_ack = 1'b0;
    assign ext_data_in = loop ? ext_data_out : drv_data;
    assign ack_in      = loop ? ack_out : drv_ack;

    ext_link_xcvr #(
        .DATA_W(DW), .CLKS_PER_BIT(CPB), .ACK_TIMEOUT(TO),
        .MAX_RETRY(MR), .PARITY_EN(PE)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_fail(tx_fail),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
        .ext_data_out(ext_data_out), .ext_data_in(ext_data_in),
        .ack_out(ack_out), .ack_in(ack_in),
        .state_tx(state_tx), .state_rx(state_rx)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected wire image: bit 0 = start ... bit 11 = stop.
    function automatic logic [11:0] frame(input logic [7:0] d, input logic s);
        frame = {1'b1, ^{s, d}, d, s, 1'b0};
    endfunction

    // Scoreboard and event counters, sampled on the falling edge.
    logic [DW-1:0] rxq[$];
    int nvalid = 0, nerr = 0, nack = 0, max_rx_st = 0;

    always @(negedge clk) begin
        if (reset) begin
            if (rx_valid) begin
                nvalid++;
                chk("rx_sb_pending", 32'(rxq.size() != 0), 1);
                if (rxq.size() != 0) chk("rx_data_sb", 32'(rx_data), 32'(rxq.pop_front()));
            end
            if (rx_err) nerr++;
            if (ack_out) nack++;
            if (int'(state_rx) > max_rx_st) max_rx_st = int'(state_rx);
        end
    end

    // Returns with t0 = cyc of the first cycle after acceptance.
    task automatic start_tx(input logic [7:0] d, output int t0);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        t0 = cyc;
    endtask

    task automatic drive_frame(input logic [11:0] f);
        @(negedge clk);
        for (int b = 0; b < 12; b++) begin
            drv_data = f[b];
            repeat (CPB) @(negedge clk);
        end
        drv_data = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    logic cap [0:399];
    logic bcap [0:399];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t0, t_wait, t_done, t_valid, fail_at, nf, ok;
        int v0, a0, e0;
        logic [11:0] f;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        chk("rst_ext_data_out", 32'(ext_data_out), 1);
        chk("rst_ack_out", 32'(ack_out), 0);
        chk("rst_tx_busy", 32'(tx_busy), 0);
        chk("rst_pulses", 32'({tx_done, tx_fail, rx_valid, rx_err}), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_state_tx", 32'(state_tx), 0);
        chk("rst_state_rx", 32'(state_rx), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- loopback 0xA5 ----------------
        loop = 1'b1;
        rxq.push_back(8'hA5);
        start_tx(8'hA5, t0);
        chk("lb_busy_after_start", 32'(tx_busy), 1);
        chk("lb_start_bit", 32'(ext_data_out), 0);
        t_wait = -1; t_done = -1; t_valid = -1;
        for (int i = 0; i < 200 && t_done < 0; i++) begin
            @(posedge clk); #1;
            if (state_tx == 3'd6 && t_wait < 0) t_wait = cyc - t0;
            if (rx_valid && t_valid < 0) t_valid = cyc - t0;
            if (tx_done) t_done = cyc - t0;
        end
        chk("lb_frame_len", 32'(t_wait), 48);
        chk("lb_rx_valid_time", 32'(t_valid), 49);
        chk("lb_tx_done_time", 32'(t_done), 52);
        @(posedge clk); #1;
        chk("lb_busy_after_done", 32'(tx_busy), 0);
        chk("lb_rx_data", 32'(rx_data), 32'h A5);

        // ---------------- no ack: retries then fail ----------------
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        loop = 1'b0; drv_ack = 1'b0; drv_data = 1'b1;
        start_tx(8'h3C, t0);
        fail_at = -1; nf = 0;
        for (int i = 0; i < 340; i++) begin
            cap[i]  = ext_data_out;
            bcap[i] = tx_busy;
            if (tx_fail) begin
                nf++;
                if (fail_at < 0) fail_at = i;
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 12; b++) f[b] = cap[k*80 + 4*b + 2];
            chk($sformatf("retry_frame%0d", k), 32'(f), 32'(frame(8'h3C, 1'b0)));
        end
        chk("retry_fail_time", 32'(fail_at), 320);
        chk("retry_fail_count", 32'(nf), 1);
        chk("retry_busy_at_fail", 32'(bcap[320]), 1);
        chk("retry_busy_after_fail", 32'(bcap[321]), 0);
        start_tx(8'h3C, t0);
        for (int i = 0; i < 48; i++) begin
            cap[i] = ext_data_out;
            @(posedge clk); #1;
        end
        for (int b = 0; b < 12; b++) f[b] = cap[4*b + 2];
        chk("next_frame_seq1", 32'(f), 32'(frame(8'h3C, 1'b1)));
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk); #1;
            if (tx_fail) ok = 1;
        end
        chk("second_fail_seen", 32'(ok), 1);

        // ---------------- duplicate suppression ----------------
        v0 = nvalid; a0 = nack;
        rxq.push_back(8'h11);
        drive_frame(frame(8'h11, 1'b0));
        chk("dup1_rx_valid", 32'(nvalid - v0), 1);
        chk("dup1_ack_cycles", 32'(nack - a0), 4);
        chk("dup1_rx_data", 32'(rx_data), 32'h11);
        v0 = nvalid; a0 = nack;
        drive_frame(frame(8'h11, 1'b0));
        chk("dup2_rx_valid", 32'(nvalid - v0), 0);
        chk("dup2_ack_cycles", 32'(nack - a0), 4);

        // ---------------- corrupted data bit ----------------
        v0 = nvalid; a0 = nack; e0 = nerr;
        drive_frame(frame(8'h0F, 1'b1) ^ 12'h004);
        chk("bad_rx_err", 32'(nerr - e0), 1);
        chk("bad_no_ack", 32'(nack - a0), 0);
        chk("bad_no_valid", 32'(nvalid - v0), 0);
        chk("bad_rx_data_held", 32'(rx_data), 32'h11);

        // ---------------- start-bit glitch ----------------
        v0 = nvalid; a0 = nack; e0 = nerr;
        @(negedge clk); max_rx_st = 0; drv_data = 1'b0;
        @(negedge clk); drv_data = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_max_state", 32'(max_rx_st), 1);
        chk("glitch_back_idle", 32'(state_rx), 0);
        chk("glitch_no_pulses", 32'((nvalid - v0) + (nerr - e0) + (nack - a0)), 0);

        // ---------------- reset during transmit DATA ----------------
        loop = 1'b1;
        start_tx(8'hC3, t0);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            if (state_tx == 3'd3) ok = 1;
        end
        chk("rst_mid_reached_data", 32'(ok), 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_ext_idle", 32'(ext_data_out), 1);
        chk("rst_mid_busy", 32'(tx_busy), 0);
        chk("rst_mid_state_tx", 32'(state_tx), 0);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        v0 = nvalid;
        rxq.push_back(8'h5A);
        start_tx(8'h5A, t0);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (i < 48) cap[i] = ext_data_out;
            @(posedge clk); #1;
            if (tx_done) ok = 1;
        end
        for (int b = 0; b < 12; b++) f[b] = cap[4*b + 2];
        chk("post_rst_frame_seq0", 32'(f), 32'(frame(8'h5A, 1'b0)));
        chk("post_rst_tx_done", 32'(ok), 1);
        repeat (4) @(negedge clk);
        chk("post_rst_rx_valid", 32'(nvalid - v0), 1);

        chk("sb_empty", 32'(rxq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
